// File: rtl/output_guard_ctrl.sv
// Output guard: gathers per-round comparator verdicts, tracks faults with leaky recovery,
// and drives relay/switch toggles, forcing safe levels in LOCK. Option: OUTCTRL_TIMEOUT_EN.
module output_guard_ctrl #(
  parameter int CH_NUM    = 2,
  parameter int STAT_W    = 8,
  parameter int ERR_BIT   = 2,
  parameter int ERR_MAX   = 3,
  parameter int CLEAR_WIN = 256,
  parameter int DRV_DIV   = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       order,
  input  logic [CH_NUM-1:0]          res_valid,
  input  logic [CH_NUM*STAT_W-1:0]   mod_status,
  input  logic                       unlock,
  output logic [1:0]                 output_status,
  output logic                       relay_ctrl,
  output logic                       switch_ctrl,
  output logic [3:0]                 err_cnt,
  output logic [CH_NUM-1:0]          err_ch
);
  localparam int GW = $clog2(CLEAR_WIN + 1);
  localparam int DW = (DRV_DIV > 1) ? $clog2(DRV_DIV) : 1;

  typedef enum logic [1:0] {IDLE, ERROR, LOCK} state_t;

  state_t            state, stateNxt;
  logic [CH_NUM-1:0] seen, seenNxt, roundErr, roundErrNxt, errChNxt;
  logic [CH_NUM-1:0] errBits, validEff, maskNext, errNext;
  logic [1:0]        statusNxt;
  logic [3:0]        errCntNxt, errCntInc;
  logic [GW-1:0]     goodCnt, goodCntNxt;
  logic [DW-1:0]     divCnt;
  logic              phase, drvQ, safeQ, orderQ;
`ifdef OUTCTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]     tmoCnt, tmoNxt;
`endif

  always_comb begin
    errBits = '0;
    for (int i = 0; i < CH_NUM; i++) errBits[i] = mod_status[i*STAT_W + ERR_BIT];
  end

  // repeat strobes from a channel already seen this round are dropped here
  assign validEff  = res_valid & ~seen;
  assign maskNext  = seen | validEff;
  assign errNext   = roundErr | (validEff & errBits);
  assign errCntInc = (err_cnt == 4'hF) ? 4'hF : err_cnt + 4'd1;

  always_comb begin
    stateNxt    = state;
    seenNxt     = seen;
    roundErrNxt = roundErr;
    statusNxt   = output_status;
    errCntNxt   = err_cnt;
    goodCntNxt  = goodCnt;
    errChNxt    = err_ch;
`ifdef OUTCTRL_TIMEOUT_EN
    tmoNxt      = tmoCnt;
`endif
    case (state)
      IDLE: begin
        seenNxt     = maskNext;
        roundErrNxt = errNext;
        statusNxt   = 2'b10;
        if (&maskNext) begin
          seenNxt     = '0;
          roundErrNxt = '0;
`ifdef OUTCTRL_TIMEOUT_EN
          tmoNxt      = '0;
`endif
          if (errNext == '0) begin
            statusNxt = 2'b00;
            if (goodCnt == GW'(CLEAR_WIN - 1)) begin
              goodCntNxt = '0;
              if (err_cnt != 4'd0) errCntNxt = err_cnt - 4'd1;
            end else begin
              goodCntNxt = goodCnt + GW'(1);
            end
          end else begin
            stateNxt  = ERROR;
            statusNxt = 2'b01;
            errChNxt  = errNext;
          end
        end
`ifdef OUTCTRL_TIMEOUT_EN
        else if (maskNext != '0) begin
          if (tmoCnt == TW'(TIMEOUT - 1)) begin
            stateNxt    = ERROR;
            statusNxt   = 2'b01;
            errChNxt    = ~maskNext;
            seenNxt     = '0;
            roundErrNxt = '0;
            tmoNxt      = '0;
          end else begin
            tmoNxt = tmoCnt + TW'(1);
          end
        end
`endif
      end
      ERROR: begin
        goodCntNxt  = '0;
        errCntNxt   = errCntInc;
        seenNxt     = res_valid;
        roundErrNxt = res_valid & errBits;
        if (errCntInc >= 4'(ERR_MAX)) begin
          stateNxt    = LOCK;
          statusNxt   = 2'b11;
          seenNxt     = '0;
          roundErrNxt = '0;
        end else begin
          stateNxt  = IDLE;
          statusNxt = 2'b10;
        end
      end
      LOCK: begin
        seenNxt     = '0;
        roundErrNxt = '0;
        statusNxt   = 2'b11;
        if (unlock) begin
          stateNxt   = IDLE;
          statusNxt  = 2'b10;
          errCntNxt  = 4'd0;
          goodCntNxt = '0;
          errChNxt   = '0;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      seen          <= '0;
      roundErr      <= '0;
      output_status <= 2'b10;
      err_cnt       <= 4'd0;
      goodCnt       <= '0;
      err_ch        <= '0;
`ifdef OUTCTRL_TIMEOUT_EN
      tmoCnt        <= '0;
`endif
    end else begin
      state         <= stateNxt;
      seen          <= seenNxt;
      roundErr      <= roundErrNxt;
      output_status <= statusNxt;
      err_cnt       <= errCntNxt;
      goodCnt       <= goodCntNxt;
      err_ch        <= errChNxt;
`ifdef OUTCTRL_TIMEOUT_EN
      tmoCnt        <= tmoNxt;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divCnt <= '0;
      phase  <= 1'b0;
      drvQ   <= 1'b1;
      safeQ  <= 1'b1;
    end else begin
      safeQ <= (stateNxt == LOCK);
      drvQ  <= phase ^ order;
      if (state == LOCK) begin
        divCnt <= '0;
        phase  <= 1'b0;
      end else if (divCnt == DW'(DRV_DIV - 1)) begin
        divCnt <= '0;
        phase  <= ~phase;
      end else begin
        divCnt <= divCnt + DW'(1);
      end
    end
  end

  // unreset on purpose: the safe switch level follows order even while reset is held
  always_ff @(posedge clk) orderQ <= order;

  assign relay_ctrl  = safeQ ? 1'b1    : drvQ;
  assign switch_ctrl = safeQ ? ~orderQ : drvQ;
endmodule
